// File: rtl/codec_config_sequencer.sv
// Audio codec register-table sequencer: walks a fixed configuration table and
// issues one I2C write per entry, paced by a divided clock, with retry and timeout.
module codec_config_sequencer #(
    parameter int unsigned CLK_DIV   = 1250,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned NUM_REGS  = 11,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    output logic        I2C_CLK,
    output logic [23:0] I2C_DATA,
    output logic        GO,
    output logic        W_R,
    input  logic        END,
    input  logic        ACK,
    output logic [3:0]  LUT_INDEX,
    output logic        DONE,
    output logic        ERROR
);

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned PH_W    = 6;
    localparam int unsigned TIMEOUT = 48;
    localparam int unsigned RTY_W   = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SEND, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               i2c_clk_q, i2c_clk_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [3:0]         idx_q, idx_d;
    logic               seen_low_q, seen_low_d;
    logic               nack_q, nack_d;
    logic               pend_q, pend_d;
    logic               start_sync_q, start_prev_q;
    logic               go_q, go_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [23:0]        data_q, data_d;
    logic               div_term_c, fall_tick_c, start_rise_c, ack_ok_c;

    function automatic logic [15:0] lut_word(input logic [3:0] i);
        case (i)
            4'd0:    lut_word = 16'h1E00;
            4'd1:    lut_word = 16'h001A;
            4'd2:    lut_word = 16'h021A;
            4'd3:    lut_word = 16'h047B;
            4'd4:    lut_word = 16'h067B;
            4'd5:    lut_word = 16'h08F8;
            4'd6:    lut_word = 16'h0A06;
            4'd7:    lut_word = 16'h0C00;
            4'd8:    lut_word = 16'h0E01;
            4'd9:    lut_word = 16'h1002;
            4'd10:   lut_word = 16'h1201;
            default: lut_word = 16'h0000;
        endcase
    endfunction

    // Slow clock divider; the FSM only moves on the falling edge of I2C_CLK
    always_comb begin
        div_term_c   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d        = div_term_c ? '0 : div_q + DIV_W'(1);
        i2c_clk_d    = i2c_clk_q ^ div_term_c;
        fall_tick_c  = div_term_c & i2c_clk_q;
        start_rise_c = start_sync_q & ~start_prev_q;
        ack_ok_c     = ~ACK & ~nack_q;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            i2c_clk_q    <= 1'b0;
            phase_q      <= '0;
            retry_q      <= '0;
            idx_q        <= '0;
            seen_low_q   <= 1'b0;
            nack_q       <= 1'b0;
            pend_q       <= 1'b1;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            go_q         <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            data_q       <= {DEV_ADDR, 16'h1E00};
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            i2c_clk_q    <= i2c_clk_d;
            phase_q      <= phase_d;
            retry_q      <= retry_d;
            idx_q        <= idx_d;
            seen_low_q   <= seen_low_d;
            nack_q       <= nack_d;
            pend_q       <= pend_d;
            start_sync_q <= START;
            start_prev_q <= start_sync_q;
            go_q         <= go_d;
            done_q       <= done_d;
            error_q      <= error_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fall_tick_c) begin
            case (state_q)
                S_IDLE:  if (pend_q) state_d = S_ARM;
                S_ARM:   if (phase_q == PH_W'(1)) state_d = S_SEND;
                S_SEND:  if ((END && seen_low_q) || phase_q == PH_W'(TIMEOUT - 1)) state_d = S_CHECK;
                S_CHECK: begin
                    if (ack_ok_c)
                        state_d = (idx_q + 4'd1 == 4'(NUM_REGS)) ? S_DONE : S_ARM;
                    else
                        state_d = (retry_q + RTY_W'(1) == RTY_W'(MAX_RETRY)) ? S_FAIL : S_ARM;
                end
                S_DONE, S_FAIL: if (pend_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        phase_d    = phase_q;
        retry_d    = retry_q;
        idx_d      = idx_q;
        seen_low_d = seen_low_q;
        nack_d     = nack_q;
        pend_d     = pend_q;
        done_d     = done_q;
        error_d    = error_q;

        if (state_d != state_q)
            phase_d = '0;
        else if (fall_tick_c && (state_q == S_ARM || state_q == S_SEND))
            phase_d = phase_q + PH_W'(1);

        if (state_q != S_SEND)
            seen_low_d = 1'b0;
        else if (fall_tick_c && !END)
            seen_low_d = 1'b1;

        // A SEND that leaves without a genuine completion is a forced NACK
        if (state_q == S_SEND && state_d == S_CHECK)
            nack_d = ~(END & seen_low_q);

        if (state_q == S_IDLE && state_d == S_ARM) begin
            idx_d   = '0;
            retry_d = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        if (state_q == S_CHECK && fall_tick_c) begin
            if (ack_ok_c) begin
                retry_d = '0;
                idx_d   = idx_q + 4'd1;
            end else begin
                retry_d = retry_q + RTY_W'(1);
            end
        end
        if (state_d == S_DONE && state_q == S_CHECK) done_d  = 1'b1;
        if (state_d == S_FAIL && state_q == S_CHECK) error_d = 1'b1;

        if (state_q == S_ARM || state_q == S_SEND || state_q == S_CHECK)
            pend_d = 1'b0;
        else if (start_rise_c)
            pend_d = 1'b1;
        else if (state_q == S_IDLE && state_d == S_ARM)
            pend_d = 1'b0;

        go_d   = (state_d == S_SEND);
        data_d = {DEV_ADDR, lut_word(idx_d)};
    end

    assign I2C_CLK   = i2c_clk_q;
    assign I2C_DATA  = data_q;
    assign GO        = go_q;
    assign W_R       = 1'b0;
    assign LUT_INDEX = idx_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural I2C controller model.
module tb_codec_config_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        i2c_clk;
    logic [23:0] i2c_data;
    logic        go;
    logic        w_r;
    logic        end_r = 1'b1;
    logic        ack_r = 1'b0;
    logic [3:0]  lut_index;
    logic        done;
    logic        error;

    int mode = 0;
    int n_vec = 0;
    int n_bad = 0;
    int both_cnt = 0;
    int mcnt = 0;
    int nack3 = 0;
    logic go_prev = 1'b0;
    logic [23:0] xlog[$];
    logic [15:0] exp_tab[11];

    typedef struct {
        int         mode;
        logic       exp_done;
        logic       exp_err;
        logic [3:0] exp_idx;
        int         exp_xfers;
    } vec_t;
    vec_t vecs[4];

    codec_config_sequencer #(.CLK_DIV(4)) dut (
        .CLOCK(clk), .RESET(rst_n), .START(start), .I2C_CLK(i2c_clk),
        .I2C_DATA(i2c_data), .GO(go), .W_R(w_r), .END(end_r), .ACK(ack_r),
        .LUT_INDEX(lut_index), .DONE(done), .ERROR(error)
    );

    always #5 clk = ~clk;

    // Controller model: END low for 6 I2C_CLK cycles after GO, then END high with ACK
    always @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt = 0; nack3 = 0; end_r = 1'b1; ack_r = 1'b0;
        end else if (mode == 3) begin
            end_r = 1'b1; ack_r = 1'b0;
        end else if (!go) begin
            mcnt = 0; end_r = 1'b1;
        end else if (mcnt < 6) begin
            end_r = 1'b0; mcnt++;
        end else if (mcnt == 6) begin
            end_r = 1'b1; mcnt++;
            if (mode == 1) begin
                ack_r = (lut_index == 4'd3 && nack3 < 2);
                if (lut_index == 4'd3) nack3++;
            end else if (mode == 2) begin
                ack_r = (lut_index == 4'd5);
            end else begin
                ack_r = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) xlog.delete();
        else if (go && !go_prev) xlog.push_back(i2c_data);
        go_prev = go;
        if (done && error) both_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input string name);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done || error) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_go(input int idx, input string name);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (go && (idx < 0 || int'(lut_index) == idx)) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_seq(input int m);
        int q[$];
        for (int i = 0; i < 11; i++) begin
            if (m == 1 && i == 3) begin q.push_back(3); q.push_back(3); end
            if (m == 2 && i == 5) begin q.push_back(5); q.push_back(5); q.push_back(5); break; end
            if (m == 3) begin q.push_back(0); q.push_back(0); q.push_back(0); break; end
            q.push_back(i);
        end
        for (int k = 0; k < q.size() && k < xlog.size(); k++)
            chk($sformatf("m%0d_xfer%0d_data", m, k), 32'(xlog[k]), {8'h0, 8'h34, exp_tab[q[k]]});
    endtask

    initial begin
        exp_tab = '{16'h1E00, 16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h08F8,
                    16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};
        vecs[0] = '{0, 1'b1, 1'b0, 4'd11, 11};
        vecs[1] = '{1, 1'b1, 1'b0, 4'd11, 13};
        vecs[2] = '{2, 1'b0, 1'b1, 4'd5, 8};
        vecs[3] = '{3, 1'b0, 1'b1, 4'd0, 3};

        repeat (2) @(negedge clk);
        chk("rst_i2c_clk", 32'(i2c_clk), 32'd0);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_flags", {30'd0, done, error}, 32'd0);
        chk("rst_index", 32'(lut_index), 32'd0);
        chk("rst_w_r", 32'(w_r), 32'd0);

        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            apply_reset();
            wait_end($sformatf("v%0d", v));
            repeat (200) @(negedge clk);
            chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_index", v), 32'(lut_index), 32'(vecs[v].exp_idx));
            chk($sformatf("v%0d_xfers", v), 32'(xlog.size()), 32'(vecs[v].exp_xfers));
            check_seq(mode);
        end

        // START during SEND of index 2 is dropped; START after DONE reruns
        mode = 0;
        apply_reset();
        wait_go(2, "start_mid");
        start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
        wait_end("start_mid");
        chk("start_mid_done", {30'd0, done, error}, 32'd2);
        chk("start_mid_xfers", 32'(xlog.size()), 32'd11);
        start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
        wait_go(0, "rerun");
        chk("rerun_done_clr", 32'(done), 32'd0);
        chk("rerun_data", 32'(i2c_data), 32'h00341E00);
        wait_end("rerun");
        chk("rerun_xfers", 32'(xlog.size()), 32'd22);

        // Reset in the middle of index 6 transfer
        apply_reset();
        wait_go(6, "rst_mid");
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_go", 32'(go), 32'd0);
        chk("rst_mid_index", 32'(lut_index), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_go(-1, "rst_after");
        chk("rst_after_data", 32'(i2c_data), 32'h00341E00);

        chk("done_error_exclusive", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
CODEC_CONFIG_SEQUENCER -- requirements
Module: codec_config_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 1250, SHALL set CLOCK cycles per I2C_CLK half-period (50 MHz -> 20 kHz); legal range 2..65535.
REQ-002 Parameter DEV_ADDR, default 8'h34, SHALL be the write slave address placed in I2C_DATA[23:16].
REQ-003 Parameter NUM_REGS, default 11, SHALL be the number of table entries sent.
REQ-004 Parameter MAX_RETRY, default 3, SHALL be the transfer attempts allowed per entry.
REQ-005 Port CLOCK, input, 1: system clock; all state on its rising edge.
REQ-006 Port RESET, input, 1: asynchronous, active-low reset.
REQ-007 Port START, input, 1: rising edge requests a full reconfiguration.
REQ-008 Port I2C_CLK, output, 1: slow clock driving the I2C controller CLOCK input.
REQ-009 Port I2C_DATA, output, 24: {DEV_ADDR, reg_addr[6:0], reg_data[8:0]} for the current entry.
REQ-010 Port GO, output, 1: transfer request to the controller.
REQ-011 Port W_R, output, 1: constant 0 (write).
REQ-012 Port END, input, 1: controller transfer-complete flag.
REQ-013 Port ACK, input, 1: controller sampled acknowledge; 1 = NACK.
REQ-014 Port LUT_INDEX, output, 4: index of the current entry.
REQ-015 Port DONE, output, 1: all entries sent successfully.
REQ-016 Port ERROR, output, 1: an entry exhausted MAX_RETRY.

Function
REQ-017 The divider SHALL count 0..CLK_DIV-1 and toggle I2C_CLK at terminal count; fall_tick SHALL be a one-CLOCK pulse on the cycle I2C_CLK goes 1->0.
REQ-018 FSM states SHALL advance only on fall_tick (END/ACK mid-period stable; GO changes before the controller's next rising edge).
REQ-019 The table SHALL hold, indices 0..10: 16'h1E00, 001A, 021A, 047B, 067B, 08F8, 0A06, 0C00, 0E01, 1002, 1201; I2C_DATA[15:0] SHALL equal table[LUT_INDEX].
REQ-020 States: IDLE, ARM, SEND, CHECK, DONE, FAIL; GO=1 only in SEND.
REQ-021 IDLE: if start pending -> clear pending, LUT_INDEX=0, retry=0, DONE=0, ERROR=0, go ARM.
REQ-022 ARM: GO=0 for exactly 2 fall_ticks (controller counter resets), then SEND.
REQ-023 SEND: SHALL set flag seen_low when END=0; on END=1 with seen_low -> CHECK.
REQ-024 SEND timeout: 48 fall_ticks without completing SHALL be treated as NACK -> CHECK path with nack forced.
REQ-025 CHECK: ACK=0 -> retry=0, LUT_INDEX+1; if new index==NUM_REGS -> DONE, else ARM.
REQ-026 CHECK: ACK=1 -> retry+1; if retry==MAX_RETRY -> FAIL, else ARM with same LUT_INDEX.
REQ-027 DONE: DONE=1 held; FAIL: ERROR=1 held, LUT_INDEX frozen at failing entry; both return to IDLE when start pending.
REQ-028 START rising edge SHALL be detected on CLOCK and latched as pending; pending SHALL be ignored (cleared) while in ARM/SEND/CHECK.
REQ-029 DONE and ERROR SHALL never be 1 simultaneously.
REQ-030 retry counter width SHALL be 2 bits minimum; LUT_INDEX SHALL not wrap past NUM_REGS.

Reset
REQ-031 RESET=0 SHALL asynchronously force: I2C_CLK=0, divider=0, GO=0, LUT_INDEX=0, DONE=0, ERROR=0, retry=0, state IDLE, start pending=1 (auto-configure after reset).
REQ-032 RESET asserted mid-transfer SHALL drop GO immediately; after release the full sequence restarts from index 0.

Verification
REQ-033 CLK_DIV=4, controller model always ACK=0 -> 11 transfers, I2C_DATA[23:16]=8'h34 each, DONE=1, LUT_INDEX=11, ERROR=0.
REQ-034 NACK on index 3 for first 2 attempts only -> index 3 sent 3 times, then DONE=1, ERROR=0.
REQ-035 NACK always on index 5 -> 3 attempts, ERROR=1, DONE=0, LUT_INDEX=5.
REQ-036 END held 1 forever (dead controller) -> timeout per attempt, ERROR=1 at index 0 after 3 attempts.
REQ-037 START pulse during SEND of index 2 -> ignored, sequence completes DONE=1; START pulse after DONE -> DONE=0, rerun from 16'h1E00.
REQ-038 RESET low during index 6 SEND -> GO=0 same cycle; after release, first I2C_DATA=24'h341E00.
